// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared constants and types for the GPR write-back arbiter.
`ifndef FCU_DDATA_WIDTH
`define FCU_DDATA_WIDTH 64
`endif

package gpr_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DDATA_W    = `FCU_DDATA_WIDTH;

  // Which path owns the write port in a given cycle.
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_MEM  = 2'd2
  } wb_src_e;

  // x0 is hardwired to zero and must never see a write.
  function automatic logic rd_writable(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_wb_result_fifo.sv
// Synchronous FIFO of {rd, data} memory results with occupancy count.
module wb_result_fifo #(
  parameter int unsigned Width           = 69,
  parameter int unsigned Depth           = 2,
  parameter bit          PushPopWhenFull = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || (PushPopWhenFull && pop_ok));

  // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AddrW'(1);
    if (pop_ok)  rptr_d = rptr_q + AddrW'(1);
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter: merges ALU and memory results onto the single GPR write port.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DDATA_W,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_vld,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_rdy,
  input  logic                  mem_vld,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_rdy,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  byp_vld,
  output logic [REG_ADDR_W-1:0] byp_addr,
  output logic [DATA_W-1:0]     byp_data
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
  localparam int unsigned EntW = REG_ADDR_W + DATA_W;

  logic                  fifo_push, fifo_pop;
  logic [EntW-1:0]       fifo_wdata, fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_empty;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;

  logic [StW-1:0]        starve_q, starve_d;
  logic                  force_mem;
  logic                  fall_through;
  wb_src_e               src;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0]     sel_data;

  logic                  wb_en_q, wb_en_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;

  wb_result_fifo #(
    .Width           (EntW),
    .Depth           (FIFO_DEPTH),
    .PushPopWhenFull (1'b1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign head_rd    = fifo_rdata[EntW-1 -: REG_ADDR_W];
  assign head_data  = fifo_rdata[DATA_W-1:0];
  assign force_mem  = (starve_q == StW'(STARVE_MAX)) && !fifo_empty;

  // Grant selection and starvation counter next-state.
  always_comb begin
    src          = WB_SRC_NONE;
    fifo_pop     = 1'b0;
    fall_through = 1'b0;
    alu_rdy      = 1'b1;
    starve_d     = starve_q;
    if (force_mem) begin
      src      = WB_SRC_MEM;
      fifo_pop = 1'b1;
      alu_rdy  = 1'b0;
      starve_d = '0;
    end else if (alu_vld) begin
      src = WB_SRC_ALU;
      if (fifo_empty) begin
        starve_d = '0;
      end else if (starve_q != StW'(STARVE_MAX)) begin
        starve_d = starve_q + StW'(1);
      end
    end else if (!fifo_empty) begin
      src      = WB_SRC_MEM;
      fifo_pop = 1'b1;
      starve_d = '0;
    end else if (mem_vld) begin
      // Empty FIFO and idle ALU: forward the memory result without storing it.
      src          = WB_SRC_MEM;
      fall_through = 1'b1;
      starve_d     = '0;
    end
  end

  // Ready reflects occupancy after this cycle's dequeue, so a full FIFO can push and pop together.
  assign mem_rdy    = (fifo_count < CntW'(FIFO_DEPTH)) || fifo_pop;
  assign fifo_push  = mem_vld && mem_rdy && !fall_through && rd_writable(mem_rd);
  assign fifo_wdata = {mem_rd, mem_data};

  // Mux the granted result and drop writes to x0.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    unique case (src)
      WB_SRC_ALU: begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
      end
      WB_SRC_MEM: begin
        sel_rd   = fall_through ? mem_rd   : head_rd;
        sel_data = fall_through ? mem_data : head_data;
      end
      default: ;
    endcase
    wb_en_d   = (src != WB_SRC_NONE) && rd_writable(sel_rd);
    wb_addr_d = wb_en_d ? sel_rd   : '0;
    wb_data_d = wb_en_d ? sel_data : '0;
  end

  // Registered write port and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign byp_vld  = wb_en_q;
  assign byp_addr = wb_addr_q;
  assign byp_data = wb_data_q;

`ifndef SYNTHESIS
  logic                  stall_q;
  logic [REG_ADDR_W-1:0] stall_rd_q;
  logic [DATA_W-1:0]     stall_data_q;

  // Remember a refused memory result so the source's hold can be checked next cycle.
  always_ff @(posedge clk) begin
    stall_q      <= !rst && mem_vld && !mem_rdy;
    stall_rd_q   <= mem_rd;
    stall_data_q <= mem_data;
  end

  // A refused memory result must still be presented unchanged.
  always_ff @(posedge clk) begin
    if (!rst && stall_q) begin
      assert (mem_vld && (mem_rd == stall_rd_q) && (mem_data == stall_data_q));
    end
  end
`endif

endmodule
